fir_stream_sink: RTL
====================

// Module: fir_stream_sink
// PURPOSE
//  Receiving end of the FIR core's Avalon-ST source: captures filtered samples (ast_source_data/valid/error),
//  discards errored beats, buffers them in a small FIFO and replays them to the DAC path at a fixed paced rate
//  (one sample per PACE clk). Absorbs the FIR's bursty valid pattern; exports error/drop/underflow statistics.
// PARAMETERS
//  DATA_W  14  sample width (signed two's complement in, offset binary out)
//  DEPTH   16  FIFO depth, power of 2, >=4
//  AFULL   12  fill level at/above which ast_sink_ready deasserts; AFULL < DEPTH
//  PACE    2   clk cycles per output sample (2 -> 50 MS/s at 100 MHz); >=1
// PORTS
//  clk             in   1              system clock, 100 MHz
//  reset_n         in   1              asynchronous, active-low reset
//  ast_sink_data   in   DATA_W         signed sample from FIR ast_source_data
//  ast_sink_valid  in   1              beat qualifier from FIR ast_source_valid
//  ast_sink_error  in   2              FIR ast_source_error; nonzero = bad beat
//  ast_sink_ready  out  1              registered, = (fill < AFULL); advisory (FIR core may ignore it)
//  out_data        out  DATA_W         offset-binary sample to DAC
//  out_strobe      out  1              1-clk pulse, out_data updated in the same cycle
//  out_underflow   out  1              1-clk pulse: pace tick found FIFO empty
//  fill_level      out  $clog2(DEPTH)+1  current FIFO occupancy
//  err_count       out  16             beats dropped for error, saturating at 16'hFFFF
//  drop_count      out  16             valid beats dropped because FIFO full, saturating
// BEHAVIOUR
//  Reset (async assert, sync release): out_data=1<<(DATA_W-1) (midscale), out_strobe=0, out_underflow=0,
//   ast_sink_ready=0, fill_level=0, counters=0, FSM=PRIME, pace counter=0, FIFO pointers=0.
//   Reset mid-operation discards FIFO contents; no strobe in the reset-release cycle.
//  Accept: valid && error==0 && (fill<DEPTH || pop this cycle) -> push ast_sink_data.
//   valid && error!=0 -> not pushed, err_count+1 (error check takes priority over full).
//   valid && error==0 && fill==DEPTH && no pop -> not pushed, drop_count+1.
//  Push at edge N -> fill_level/ast_sink_ready reflect it after edge N. Push+pop same cycle: fill unchanged.
//  FSM:
//   PRIME: pace counter held at 0, no pops, no strobes; fill >= DEPTH/2 -> RUN.
//   RUN:   pace counter counts 0..PACE-1, wraps; tick = (count==PACE-1).
//          tick && fill>0  -> pop; out_data <= {~d[DATA_W-1], d[DATA_W-2:0]}; out_strobe=1.
//          tick && fill==0 -> out_data held, out_strobe=0, out_underflow=1, -> PRIME.
//   PACE==1: tick every cycle in RUN.
//  Latency: first strobe = PACE cycles after PRIME->RUN transition edge; sample order preserved (FIFO).
//  Pointers wrap modulo DEPTH; fill_level ranges 0..DEPTH inclusive.
//  Counters saturate; they never wrap and clear only on reset.
// STRUCTURE
//  Package fir_stream_pkg: state enum {PRIME, RUN}, default DATA_W=14, function to_offset_bin(sample).
//  Sub-module sync_fifo (DATA_W, DEPTH): push/pop/din/dout/fill, first-word-fall-through dout,
//   simultaneous push+pop legal when full. Top: accept logic, FSM, pace counter, stats counters.
// TESTING
//  1 Reset: hold reset_n=0 with valid toggling -> out_data=14'h2000, ready=0, no strobe, counters 0.
//  2 Prime/run: feed 0,1,..,9 at valid every 2nd clk, PACE=2 -> no strobe until fill=8; then strobes every
//    2 clk with out_data 14'h2000,14'h2001,...,14'h2009 in order.
//  3 Error drop: beat 5 with error=2'b01 -> sample absent from output, err_count=1, drop_count=0.
//  4 Overflow: valid every clk, stall-free, ready ignored -> fill saturates at 16; ready=0 at fill>=12;
//    extra beats increment drop_count once each; output sequence has no duplicates.
//  5 Underflow: stop input after 8 beats -> 8 strobes, then out_underflow pulse, out_data holds last value,
//    FSM back to PRIME (no strobes until fill reaches 8 again).
//  6 Mid-run reset: assert reset_n=0 with fill=6 -> immediate midscale output, fill 0; after release,
//    rerun scenario 2 -> identical result. Also check signed extremes: -8192 -> 14'h0000, 8191 -> 14'h3FFF.

Source files
------------

// File: rtl/fir_stream_pkg.sv
// rtl/fir_stream_pkg.sv - shared types and helpers for the FIR stream sink
package fir_stream_pkg;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int DEFAULT_DATA_W = 14;

    // Two's complement to offset binary is a flip of the sign bit at position width-1.
    function automatic logic [31:0] to_offset_bin(input logic [31:0] sample, input int width);
        return sample ^ (32'd1 << (width - 1));
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO with occupancy count
module sync_fifo #(
    parameter int DATA_W = 14,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic [$clog2(DEPTH):0]   fill
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    // Storage array; the caller only pushes when there is room (or a pop frees a slot this cycle).
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally modulo DEPTH; fill tracks occupancy 0..DEPTH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fill <= fill + FW'(1);
                2'b01:   fill <= fill - FW'(1);
                default: fill <= fill;
            endcase
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/fir_stream_sink.sv
// rtl/fir_stream_sink.sv - buffers FIR output beats and replays them at a fixed pace
module fir_stream_sink
    import fir_stream_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = 16,
    parameter int AFULL  = 12,
    parameter int PACE   = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [DATA_W-1:0]        ast_sink_data,
    input  logic                     ast_sink_valid,
    input  logic [1:0]               ast_sink_error,
    output logic                     ast_sink_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_strobe,
    output logic                     out_underflow,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic [15:0]              err_count,
    output logic [15:0]              drop_count
);
    localparam int FW = $clog2(DEPTH) + 1;
    localparam int CW = (PACE > 1) ? $clog2(PACE) : 1;

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     pace_cnt;
    logic [CW-1:0]     pace_nxt;
    logic              tick;
    logic              pop;
    logic              push;
    logic              underflow_nxt;
    logic              beat_good;
    logic              beat_err;
    logic              beat_drop;
    logic [FW-1:0]     fill;
    logic [FW-1:0]     fill_nxt;
    logic [DATA_W-1:0] fifo_dout;

    assign fill_level = fill;

    // Error beats are rejected before the full check so they never count as drops.
    assign beat_err  = ast_sink_valid && (ast_sink_error != 2'b00);
    assign beat_good = ast_sink_valid && (ast_sink_error == 2'b00);
    assign push      = beat_good && ((fill != FW'(DEPTH)) || pop);
    assign beat_drop = beat_good && !push;
    assign fill_nxt  = fill + FW'(push) - FW'(pop);

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (ast_sink_data),
        .dout    (fifo_dout),
        .fill    (fill)
    );

    // Pacing FSM: wait in PRIME until half full, then pop one sample per PACE cycles.
    always_comb begin
        state_nxt     = state;
        pace_nxt      = '0;
        tick          = 1'b0;
        pop           = 1'b0;
        underflow_nxt = 1'b0;
        if (state == PRIME) begin
            if (fill >= FW'(DEPTH / 2)) begin
                state_nxt = RUN;
            end
        end else begin
            tick     = (pace_cnt == CW'(PACE - 1));
            pace_nxt = tick ? '0 : pace_cnt + CW'(1);
            if (tick) begin
                if (fill != '0) begin
                    pop = 1'b1;
                end else begin
                    underflow_nxt = 1'b1;
                    state_nxt     = PRIME;
                end
            end
        end
    end

    // Registered outputs, FSM state, ready flag and saturating statistics.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= PRIME;
            pace_cnt       <= '0;
            out_data       <= {1'b1, {(DATA_W-1){1'b0}}};
            out_strobe     <= 1'b0;
            out_underflow  <= 1'b0;
            ast_sink_ready <= 1'b0;
            err_count      <= '0;
            drop_count     <= '0;
        end else begin
            state          <= state_nxt;
            pace_cnt       <= pace_nxt;
            out_strobe     <= pop;
            out_underflow  <= underflow_nxt;
            ast_sink_ready <= (fill_nxt < FW'(AFULL));
            if (pop) begin
                out_data <= DATA_W'(to_offset_bin(32'(fifo_dout), DATA_W));
            end
            if (beat_err && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
            if (beat_drop && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

endmodule
